mul_ctrl: RTL and testbench
===========================

Name: mul_ctrl

Overview:
- Sequencing controller between the EX stage and the 8-cycle Booth/Wallace multiplier (`mul`).
- Decodes RV64M multiply ops, latches operands and holds them stable for the whole computation, and launches the multiplier with a one-cycle pulse.
- Captures the one-cycle multiplier result, selects and sign-extends the requested half, and returns it over a valid/ready response interface.
- Handles pipeline flush and backpressure.

Parameters:
- XLEN, 64, operand/result width; only 64 is supported.
- TAG_W, 5, width of the opaque tag (rd index) carried from request to response.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush; aborts any in-flight op
- req_valid  in  1  EX request valid
- req_ready  out  1  controller can accept a request
- req_op  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 MULW; others decode as MUL
- req_rs1  in  XLEN  operand A
- req_rs2  in  XLEN  operand B
- req_tag  in  TAG_W  tag
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accepts result
- resp_data  out  XLEN  result
- resp_tag  out  TAG_W  tag of the result
- busy  out  1  state != IDLE
- mul_valid  out  1  launch pulse to the multiplier
- mul_flush  out  1  multiplier flush
- mul_mulw  out  1  32-bit mode
- mul_signed  out  2  00 u×u, 10 s×u, 11 s×s
- mul_a  out  XLEN  multiplicand
- mul_b  out  XLEN  multiplier
- mul_out_ready  in  1  multiplier idle
- mul_out_valid  in  1  one-cycle result strobe
- mul_hi  in  XLEN  high half of the product
- mul_lo  in  XLEN  low half of the product

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - Operand, result and tag registers are 0.
  - All outputs are 0 except req_ready, which follows its equation.
- States: IDLE, ISSUE, WAIT, RESP.
- req_ready = (state==IDLE) & mul_out_ready & !flush.
- IDLE:
  - On req_valid&req_ready, latch op, rs1, rs2 and tag.
  - Go to ISSUE.
- ISSUE:
  - mul_valid=1 for exactly this cycle.
  - Go to WAIT.
- WAIT:
  - On mul_out_valid, register the selected result and go to RESP.
- RESP:
  - resp_valid held until resp_ready; on the handshake go to IDLE.
  - resp_data/resp_tag are stable while resp_valid=1.
- Multiplier drive:
  - mul_a/mul_b/mul_mulw/mul_signed are driven from the latched registers.
  - They are constant from ISSUE through the end of WAIT.
- Signedness mapping:
  - MUL and MULH → 11.
  - MULHSU → 10.
  - MULHU → 00.
  - MULW → mulw=1, signed=11.
- Result select:
  - MUL → lo.
  - MULH/MULHSU/MULHU → hi.
  - MULW → {32{lo[31]}, lo[31:0]}.
- Latency: request accepted at the edge ending cycle T → mul_valid in T+1 → mul_out_valid in T+9 → resp_valid in T+10. Minimum 10 cycles accept-to-response.
- Throughput: one op in flight. No new request is accepted before the response handshake completes.
- mul_flush = flush, passed through combinationally in every state.
- Flush:
  - Next state is IDLE; the in-flight result is discarded.
  - resp_valid = (state==RESP) & !flush, so a flush coinciding with resp_ready produces no handshake.
  - A request presented in a flush cycle is not accepted.
- mul_out_valid in any state other than WAIT is ignored.
- Async reset mid-operation returns to IDLE immediately. The multiplier is reset by the same rst_n.

Optional Feature:
- MUL_RESULT_REUSE_EN
- Defined:
  - Keep the last completed {rs1, rs2, mul_signed, hi, lo} plus a valid bit.
  - In IDLE, an accepted non-MULW request whose rs1, rs2 and signedness match the valid entry goes directly to RESP with the selected half of the stored product. Latency is 1 cycle and no mul_valid is issued. This covers MULH followed by MUL.
  - The entry is written on every mul_out_valid captured in WAIT.
  - The valid bit is cleared by reset and by flush.
  - MULW results are never stored.
- Undefined: no storage; every request goes through ISSUE/WAIT.

Test Plan:
- MUL rs1=3, rs2=5 → mul_valid pulses once in T+1; resp_valid in T+10, resp_data=15, tag echoed.
- MULH −1×−1 → 0. MULHU 0xFFFF_FFFF_FFFF_FFFF squared → 0xFFFF_FFFF_FFFF_FFFE. MULHSU −1×2 → 0xFFFF_FFFF_FFFF_FFFF.
- MULW 0x7FFF_FFFF×2 → 0xFFFF_FFFF_FFFF_FFFE; upper operand bits set to garbage do not change the result.
- resp_ready held low for 5 cycles → resp_valid/resp_data/resp_tag stable; req_ready=0 throughout; IDLE after the handshake.
- flush in WAIT (T+5) → mul_flush=1 that cycle; IDLE next cycle; no resp_valid; a new MUL 2×2 then returns 4. Flush in RESP with resp_ready=1 → no handshake.
- With MUL_RESULT_REUSE_EN: MULH a,b then MUL a,b → second response 1 cycle after accept with no mul_valid. After a flush, the same MUL takes the full 10 cycles.

Source files
------------

// File: rtl/mul_ctrl.sv
// mul_ctrl: sequences one RV64M multiply at a time through the 8-cycle
// multiplier. Operands are latched on accept and held until the result
// returns. The selected half is then offered on a valid/ready response port.
//
// Optional build macro: MUL_RESULT_REUSE_EN
//   When defined, the last stored product {rs1, rs2, signedness, hi, lo} is
//   kept. A matching non-MULW request is answered from it in one cycle,
//   without launching the multiplier.
//
// state | meaning
// IDLE  | waiting for a request
// ISSUE | one-cycle launch pulse to the multiplier
// WAIT  | operands held, waiting for the result strobe
// RESP  | result offered until the consumer takes it
module mul_ctrl #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [XLEN-1:0]  req_rs1,
  input  logic [XLEN-1:0]  req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy,
  output logic             mul_valid,
  output logic             mul_flush,
  output logic             mul_mulw,
  output logic [1:0]       mul_signed,
  output logic [XLEN-1:0]  mul_a,
  output logic [XLEN-1:0]  mul_b,
  input  logic             mul_out_ready,
  input  logic             mul_out_valid,
  input  logic [XLEN-1:0]  mul_hi,
  input  logic [XLEN-1:0]  mul_lo
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t state, state_nxt;

  logic [XLEN-1:0]  rs1_q, rs2_q, res_q;
  logic [TAG_W-1:0] tag_q;
  logic [1:0]       sgn_q;
  logic             mulw_q;
  logic             hi_q;

  logic [1:0]       req_sgn;
  logic             req_mulw;
  logic             req_hi;
  logic             accept;
  logic             capture;
  logic             hit;
  logic [XLEN-1:0]  hit_data;
  logic [XLEN-1:0]  sel_result;

  // Decode the request op into multiplier mode and result half.
  // Undefined op encodings behave as MUL.
  always_comb begin
    req_sgn  = 2'b11;
    req_mulw = 1'b0;
    req_hi   = 1'b0;
    case (req_op)
      3'b001: req_hi = 1'b1;
      3'b010: begin req_sgn = 2'b10; req_hi = 1'b1; end
      3'b011: begin req_sgn = 2'b00; req_hi = 1'b1; end
      3'b100: req_mulw = 1'b1;
      default: ;
    endcase
  end

  assign req_ready = (state == IDLE) & mul_out_ready & ~flush;
  assign accept    = req_valid & req_ready;
  assign capture   = (state == WAIT) & mul_out_valid & ~flush;

  // For MULW, only the low 32 bits of the product are used. They do not
  // depend on the upper operand bits, so garbage in those bits is harmless.
  assign sel_result = hi_q   ? mul_hi :
                      mulw_q ? {{(XLEN-32){mul_lo[31]}}, mul_lo[31:0]} :
                               mul_lo;

`ifdef MUL_RESULT_REUSE_EN
  logic            c_valid;
  logic [XLEN-1:0] c_rs1, c_rs2, c_hi, c_lo;
  logic [1:0]      c_sgn;

  assign hit = c_valid & ~req_mulw & (req_rs1 == c_rs1) &
               (req_rs2 == c_rs2) & (req_sgn == c_sgn);
  assign hit_data = req_hi ? c_hi : c_lo;

  // Remember the last non-MULW product. A flush invalidates it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_valid <= 1'b0;
      c_rs1   <= '0;
      c_rs2   <= '0;
      c_hi    <= '0;
      c_lo    <= '0;
      c_sgn   <= 2'b00;
    end else if (flush) begin
      c_valid <= 1'b0;
    end else if (capture && !mulw_q) begin
      c_valid <= 1'b1;
      c_rs1   <= rs1_q;
      c_rs2   <= rs2_q;
      c_hi    <= mul_hi;
      c_lo    <= mul_lo;
      c_sgn   <= sgn_q;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic plus the launch and response strobes.
  // A flush overrides every transition.
  always_comb begin
    state_nxt  = state;
    mul_valid  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE:  if (accept) state_nxt = hit ? RESP : ISSUE;
      ISSUE: begin
        mul_valid = 1'b1;
        state_nxt = WAIT;
      end
      WAIT:  if (mul_out_valid) state_nxt = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt  = IDLE;
      mul_valid  = 1'b0;
      resp_valid = 1'b0;
    end
  end

  // Operand, mode and tag latch on accept; result capture from the multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_q  <= '0;
      rs2_q  <= '0;
      res_q  <= '0;
      tag_q  <= '0;
      sgn_q  <= 2'b00;
      mulw_q <= 1'b0;
      hi_q   <= 1'b0;
    end else begin
      if (accept) begin
        rs1_q  <= req_rs1;
        rs2_q  <= req_rs2;
        tag_q  <= req_tag;
        sgn_q  <= req_sgn;
        mulw_q <= req_mulw;
        hi_q   <= req_hi;
        if (hit) res_q <= hit_data;
      end
      if (capture) res_q <= sel_result;
    end
  end

  assign mul_a      = rs1_q;
  assign mul_b      = rs2_q;
  assign mul_signed = sgn_q;
  assign mul_mulw   = mulw_q;
  assign mul_flush  = flush;
  assign resp_data  = res_q;
  assign resp_tag   = tag_q;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench for mul_ctrl, with a behavioural 8-cycle multiplier model.
module tb_mul_ctrl;
  logic        clk, rst_n, flush;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [63:0] req_rs1, req_rs2;
  logic [4:0]  req_tag;
  logic        resp_valid, resp_ready;
  logic [63:0] resp_data;
  logic [4:0]  resp_tag;
  logic        busy, mul_valid, mul_flush, mul_mulw;
  logic [1:0]  mul_signed;
  logic [63:0] mul_a, mul_b;
  logic        mul_out_ready, mul_out_valid;
  logic [63:0] mul_hi, mul_lo;

  int checks = 0;
  int errors = 0;
  int mv_cnt = 0;

  mul_ctrl #(.XLEN(64), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag), .busy(busy),
    .mul_valid(mul_valid), .mul_flush(mul_flush), .mul_mulw(mul_mulw),
    .mul_signed(mul_signed), .mul_a(mul_a), .mul_b(mul_b),
    .mul_out_ready(mul_out_ready), .mul_out_valid(mul_out_valid),
    .mul_hi(mul_hi), .mul_lo(mul_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: the result strobe comes 8 cycles after the launch cycle.
  logic [3:0]  mcnt;
  logic [63:0] m_hi, m_lo;

  function automatic logic [127:0] prod(input logic [63:0] a, input logic [63:0] b,
                                        input logic [1:0] s, input logic w);
    logic [127:0] ea, eb;
    if (w) begin
      ea = {{96{a[31]}}, a[31:0]};
      eb = {{96{b[31]}}, b[31:0]};
    end else begin
      ea = s[1] ? {{64{a[63]}}, a} : {64'd0, a};
      eb = s[0] ? {{64{b[63]}}, b} : {64'd0, b};
    end
    return ea * eb;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mcnt <= 4'd0;
    else if (mul_flush) mcnt <= 4'd0;
    else if (mul_valid) begin
      mcnt <= 4'd8;
      {m_hi, m_lo} <= prod(mul_a, mul_b, mul_signed, mul_mulw);
    end else if (mcnt != 4'd0) mcnt <= mcnt - 4'd1;
  end

  assign mul_out_valid = (mcnt == 4'd1);
  assign mul_out_ready = (mcnt == 4'd0);
  assign mul_hi = mul_out_valid ? m_hi : 64'd0;
  assign mul_lo = mul_out_valid ? m_lo : 64'd0;

  always @(posedge clk) if (mul_valid) mv_cnt <= mv_cnt + 1;

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, measure accept-to-response latency, check data/tag and
  // the number of multiplier launches, then complete the handshake.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] t, input logic [63:0] exp,
                        input int exp_lat, input int exp_pulses);
    int lat, mv0;
    req_op = op; req_rs1 = a; req_rs2 = b; req_tag = t; req_valid = 1'b1;
    #1;
    chk({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
    mv0 = mv_cnt;
    tick;
    req_valid = 1'b0;
    lat = 1;
    chk({tag, "_mul_valid_t1"}, {63'd0, mul_valid}, (exp_pulses != 0) ? 64'd1 : 64'd0);
    while (!resp_valid && lat < 40) begin
      tick;
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_data"}, resp_data, exp);
    chk({tag, "_tag"}, {59'd0, resp_tag}, {59'd0, t});
    chk({tag, "_launches"}, 64'(mv_cnt - mv0), 64'(exp_pulses));
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    #1;
    chk({tag, "_idle_after"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int lat;
    logic seen;
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_op = 3'd0;
    req_rs1 = 64'd0; req_rs2 = 64'd0; req_tag = 5'd0; resp_ready = 1'b0;
    #3;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_mul_valid", {63'd0, mul_valid}, 64'd0);
    chk("rst_mul_a", mul_a, 64'd0);
    chk("rst_mul_signed", {62'd0, mul_signed}, 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    tick; tick;
    rst_n = 1'b1;
    tick;

    run_op("mul_3x5", 3'b000, 64'd3, 64'd5, 5'd17, 64'd15, 10, 1);
    run_op("mulh_m1m1", 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2,
           64'd0, 10, 1);
    run_op("mulhu_max", 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3,
           64'hFFFF_FFFF_FFFF_FFFE, 10, 1);
    run_op("mulhsu_m1x2", 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd4,
           64'hFFFF_FFFF_FFFF_FFFF, 10, 1);
    run_op("mulw", 3'b100, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd5,
           64'hFFFF_FFFF_FFFF_FFFE, 10, 1);
    run_op("mulw_garbage", 3'b100, 64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0002, 5'd6,
           64'hFFFF_FFFF_FFFF_FFFE, 10, 1);

    // Backpressure: response held for 5 cycles while another request waits.
    req_op = 3'b000; req_rs1 = 64'd7; req_rs2 = 64'd6; req_tag = 5'd9; req_valid = 1'b1;
    tick;
    req_rs1 = 64'd11; req_tag = 5'd1;
    lat = 1;
    while (!resp_valid && lat < 40) begin tick; lat++; end
    chk("bp_latency", 64'(lat), 64'd10);
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid", {63'd0, resp_valid}, 64'd1);
      chk("bp_resp_data", resp_data, 64'd42);
      chk("bp_resp_tag", {59'd0, resp_tag}, 64'd9);
      chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
      tick;
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    chk("bp_idle_after", {63'd0, busy}, 64'd0);
    chk("bp_no_resp_after", {63'd0, resp_valid}, 64'd0);

    // Flush during WAIT at T+5.
    req_op = 3'b000; req_rs1 = 64'd9; req_rs2 = 64'd9; req_tag = 5'd3; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    repeat (4) tick;
    flush = 1'b1;
    #1;
    chk("fw_mul_flush", {63'd0, mul_flush}, 64'd1);
    chk("fw_busy_before", {63'd0, busy}, 64'd1);
    chk("fw_req_ready", {63'd0, req_ready}, 64'd0);
    tick;
    flush = 1'b0;
    #1;
    chk("fw_idle_next", {63'd0, busy}, 64'd0);
    seen = 1'b0;
    repeat (12) begin
      tick;
      if (resp_valid) seen = 1'b1;
    end
    chk("fw_no_resp", {63'd0, seen}, 64'd0);
    run_op("fw_mul_2x2", 3'b000, 64'd2, 64'd2, 5'd8, 64'd4, 10, 1);

    // Flush in RESP coinciding with resp_ready: no handshake.
    req_op = 3'b000; req_rs1 = 64'd5; req_rs2 = 64'd5; req_tag = 5'd4; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin tick; lat++; end
    chk("fr_latency", 64'(lat), 64'd10);
    flush = 1'b1; resp_ready = 1'b1;
    #1;
    chk("fr_resp_valid", {63'd0, resp_valid}, 64'd0);
    tick;
    flush = 1'b0; resp_ready = 1'b0;
    #1;
    chk("fr_idle", {63'd0, busy}, 64'd0);
    chk("fr_no_resp", {63'd0, resp_valid}, 64'd0);

    // Asynchronous reset mid-operation.
    req_op = 3'b000; req_rs1 = 64'd13; req_rs2 = 64'd3; req_tag = 5'd7; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    repeat (3) tick;
    rst_n = 1'b0;
    #1;
    chk("ar_busy", {63'd0, busy}, 64'd0);
    chk("ar_mul_a", mul_a, 64'd0);
    tick;
    rst_n = 1'b1;
    tick;
    run_op("ar_recover", 3'b000, 64'd10, 64'd10, 5'd10, 64'd100, 10, 1);

    // MULH then MUL on the same operands: product = 2^70 + 3*2^40.
`ifdef MUL_RESULT_REUSE_EN
    run_op("ru_mulh", 3'b001, 64'h0000_0100_0000_0000, 64'h0000_0000_4000_0003, 5'd11,
           64'h40, 10, 1);
    run_op("ru_mul_hit", 3'b000, 64'h0000_0100_0000_0000, 64'h0000_0000_4000_0003, 5'd12,
           64'h0000_0300_0000_0000, 1, 0);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    run_op("ru_mul_after_flush", 3'b000, 64'h0000_0100_0000_0000, 64'h0000_0000_4000_0003,
           5'd13, 64'h0000_0300_0000_0000, 10, 1);
`else
    run_op("nr_mulh", 3'b001, 64'h0000_0100_0000_0000, 64'h0000_0000_4000_0003, 5'd11,
           64'h40, 10, 1);
    run_op("nr_mul", 3'b000, 64'h0000_0100_0000_0000, 64'h0000_0000_4000_0003, 5'd12,
           64'h0000_0300_0000_0000, 10, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
